// File: rtl/hvsync_generator.sv
// ============================================================================
// Module   : hvsync_generator
// Purpose  : VGA-style raster timing generator with registered counters and syncs.
//            Define HVSYNC_POS_POLARITY_EN for active-high hsync/vsync.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hvsync_generator #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS        = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

`ifdef HVSYNC_POS_POLARITY_EN
  localparam logic SYNC_ACTIVE = 1'b1;
`else
  localparam logic SYNC_ACTIVE = 1'b0;
`endif

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       h_wrap;

  // Decodes work on the next-state counters so every output register lines up
  // with the position it describes.
  always_comb begin
    h_wrap = (hpos_q >= H_MAX);
    hpos_d = h_wrap ? 10'd0 : hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (h_wrap) begin
      vpos_d = (vpos_q >= V_MAX) ? 10'd0 : vpos_q + 10'd1;
    end

    hsync_d = ((hpos_d >= H_SYNC_FIRST) && (hpos_d <= H_SYNC_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = ((vpos_d >= V_SYNC_FIRST) && (vpos_d <= V_SYNC_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    display_on_d = (hpos_d < H_VIS) && (vpos_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q       <= 10'd0;
      vpos_q       <= 10'd0;
      hsync_q      <= ~SYNC_ACTIVE;
      vsync_q      <= ~SYNC_ACTIVE;
      display_on_q <= 1'b1;
    end else begin
      hpos_q       <= hpos_d;
      vpos_q       <= vpos_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      display_on_q <= display_on_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = display_on_q;

endmodule

`default_nettype wire

// File: tb/tb_hvsync_generator.sv
// ============================================================================
// Module   : tb_hvsync_generator
// Purpose  : Scoreboard bench for hvsync_generator (default and reduced timing).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hvsync_generator;

`ifdef HVSYNC_POS_POLARITY_EN
  localparam logic ACT = 1'b1;
`else
  localparam logic ACT = 1'b0;
`endif

  // Reduced timing: 25 clocks per line, 15 lines per frame, 375 clocks per frame.
  localparam int SHD = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVD = 8,  SVF = 2, SVS = 2, SVB = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       b_hs, b_vs, b_de, s_hs, s_vs, s_de;
  logic [9:0] b_h, b_v, s_h, s_v;

  always #5 clk = ~clk;

  hvsync_generator u_big (
    .clk(clk), .reset(reset), .hsync(b_hs), .vsync(b_vs),
    .display_on(b_de), .hpos(b_h), .vpos(b_v)
  );

  hvsync_generator #(
    .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs),
    .display_on(s_de), .hpos(s_h), .vpos(s_v)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int n_popped = 0;
  int n_period = 0;
  int n_line   = 0;
  int n_spot   = 0;

  logic [22:0] q_big[$];
  logic [22:0] q_sm[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {hpos, vpos, hsync, vsync, display_on} for a raster position.
  function automatic logic [22:0] exp_of(input int h, input int v, input int hd, input int hf,
                                         input int hs, input int vd, input int vf, input int vs);
    logic hsa, vsa, de;
    hsa = (h >= hd + hf) && (h < hd + hf + hs);
    vsa = (v >= vd + vf) && (v < vd + vf + vs);
    de  = (h < hd) && (v < vd);
    return {10'(h), 10'(v), (hsa ? ACT : ~ACT), (vsa ? ACT : ~ACT), de};
  endfunction

  int bh = 0, bv = 0, sh = 0, sv = 0;

  task automatic step(input logic r);
    @(negedge clk);
    reset = r;
    if (r) begin
      bh = 0; bv = 0; sh = 0; sv = 0;
    end else begin
      if (bh == 799) begin
        bh = 0;
        bv = (bv == 524) ? 0 : bv + 1;
      end else begin
        bh = bh + 1;
      end
      if (sh == 24) begin
        sh = 0;
        sv = (sv == 14) ? 0 : sv + 1;
      end else begin
        sh = sh + 1;
      end
    end
    q_big.push_back(exp_of(bh, bv, 640, 16, 96, 480, 10, 2));
    q_sm.push_back(exp_of(sh, sv, SHD, SHF, SHS, SVD, SVF, SVS));
    n_pushed++;
  endtask

  // Monitor: compares every presented cycle and gathers frame statistics.
  int   cyc = 0, last_edge = 0, de_cnt = 0, vs_cnt = 0, line_hs = 0;
  logic have_edge = 1'b0, prev_vs = 1'b1, end_seen = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_big.size() > 0 && q_sm.size() > 0) begin
        logic [22:0] eb, es;
        eb = q_big.pop_front();
        es = q_sm.pop_front();
        n_popped++;
        cyc++;
        check("big_outputs", {9'd0, b_h, b_v, b_hs, b_vs, b_de}, {9'd0, eb});
        check("small_outputs", {9'd0, s_h, s_v, s_hs, s_vs, s_de}, {9'd0, es});

        if (reset) begin
          have_edge = 1'b0; de_cnt = 0; vs_cnt = 0; line_hs = 0;
          prev_vs = ~ACT; end_seen = 1'b0;
        end else begin
          if (b_v == 10'd0 && b_hs == ACT) line_hs++;
          if (b_h == 10'd0 && b_v == 10'd1) begin
            check("line_hsync_clocks", line_hs, 96);
            n_line++;
            line_hs = 0;
          end

          if (s_vs == ACT && prev_vs != ACT) begin
            if (have_edge) begin
              check("frame_period", cyc - last_edge, 375);
              check("frame_display_clocks", de_cnt, 128);
              check("vsync_width", vs_cnt, 50);
              n_period++;
            end
            have_edge = 1'b1; last_edge = cyc; de_cnt = 0; vs_cnt = 0;
          end
          if (s_de) de_cnt++;
          if (s_vs == ACT) vs_cnt++;
          prev_vs = s_vs;

          if (end_seen) begin
            check("wrap_to_origin", {11'd0, s_h, s_v, s_de}, {11'd0, 10'd0, 10'd0, 1'b1});
            n_spot++;
          end
          if (s_h == 10'd15 && s_v == 10'd7)  begin check("de_last_visible", s_de, 1); n_spot++; end
          if (s_h == 10'd16 && s_v == 10'd7)  begin check("de_h_edge", s_de, 0); n_spot++; end
          if (s_h == 10'd15 && s_v == 10'd8)  begin check("de_v_edge", s_de, 0); n_spot++; end
          if (s_h == 10'd24 && s_v == 10'd14) begin check("de_frame_end", s_de, 0); n_spot++; end
          end_seen = (s_h == 10'd24 && s_v == 10'd14);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    repeat (3) step(1'b1);
    repeat (1000) step(1'b0);
    guard = 0;
    while (!(sh == 12 && sv == 5) && guard < 1000) begin
      step(1'b0);
      guard++;
    end
    repeat (3) step(1'b1);
    repeat (900) step(1'b0);
    repeat (3) @(negedge clk);

    check("queue_drained", q_big.size() + q_sm.size(), 0);
    check("pops_match_pushes", n_popped, n_pushed);
    check("frame_period_checks", n_period, 3);
    check("line_checks", n_line, 2);
    check("spot_coverage", (n_spot >= 10) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
